// File: rtl/or_lab_pkg.sv
// ----------------------------------------------------------------------------
// or_lab_pkg
// Constants shared by the OR-gate lab input conditioner and its debouncers:
// the number of gate inputs, the default debounce and sweep timing, and the
// encoding of the mode select input.
// ----------------------------------------------------------------------------
package or_lab_pkg;

    // Number of gate inputs driven by the conditioner (a, b, c, d).
    localparam int NUM_INPUTS = 4;

    // Default timing.
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_SWEEP_PERIOD    = 10;

    // Encoding of the mode select input.
    localparam logic MODE_SWITCH = 1'b0;  // debounced switch pass-through
    localparam logic MODE_SWEEP  = 1'b1;  // automatic 0..15 pattern sweep

    // One bit per gate input, bit0 = a ... bit3 = d.
    typedef logic [NUM_INPUTS-1:0] gate_vec_t;

endpackage : or_lab_pkg

// File: rtl/bit_debouncer.sv
// ----------------------------------------------------------------------------
// bit_debouncer
// Single-bit conditioner for one raw switch/button level: a two-flop
// synchronizer followed by a counting debouncer. The stable level only follows
// the synchronized level after it has differed for DEBOUNCE_CYCLES
// consecutive clock cycles; shorter pulses are discarded.
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset (clears everything to 0)
//   i_raw     in   asynchronous raw level
//   o_stable  out  debounced level (registered)
// ----------------------------------------------------------------------------
module bit_debouncer
    import or_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES  // legal 2..255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                // Any cycle agreeing with the stable level restarts the count,
                // so only an unbroken run of differing cycles is accepted.
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;

endmodule : bit_debouncer

// File: rtl/or_input_conditioner.sv
// ----------------------------------------------------------------------------
// or_input_conditioner
// Drives the four inputs of a downstream OR-gate stage either from debounced
// switches (mode 0) or from an automatic 4-bit sweep 0,1,...,15,0,... that
// advances every SWEEP_PERIOD cycles (mode 1). A one-cycle 'changed' pulse
// flags every cycle in which the output vector differs from the cycle before.
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset
//   sw_raw   in   [3:0] asynchronous raw switch levels, bit0->a ... bit3->d
//   mode     in   clk-synchronous select, 0 = switches, 1 = sweep
//   a,b,c,d  out  registered gate-input drive
//   changed  out  high while {d,c,b,a} differs from its previous-cycle value
// ----------------------------------------------------------------------------
module or_input_conditioner
    import or_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,  // legal 2..255
    parameter int SWEEP_PERIOD    = DEF_SWEEP_PERIOD      // legal 2..65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] sw_raw,
    input  logic                  mode,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    output logic                  changed
);

    localparam int                 TICK_W    = $clog2(SWEEP_PERIOD);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SWEEP_PERIOD - 1);

    gate_vec_t         w_stable;
    logic              w_sweep_entry;
    logic              r_mode_q;
    logic [TICK_W-1:0] r_tick;
    gate_vec_t         r_pattern;
    gate_vec_t         r_out;
    gate_vec_t         r_out_q;

    // One independent synchronizer + debouncer per switch. They run in both
    // modes so that leaving sweep mode shows up-to-date switch levels at once.
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_deb
        bit_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit_debouncer (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (sw_raw[gi]),
            .o_stable (w_stable[gi])
        );
    end

    // First cycle of sweep mode: mode has just gone from switch to sweep.
    assign w_sweep_entry = (mode == MODE_SWEEP) && (r_mode_q == MODE_SWITCH);

    // Sweep tick counter and pattern. Entering sweep restarts both from 0 and
    // takes priority over a wrap on the same edge; outside sweep they hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= '0;
            r_pattern <= '0;
        end else if (w_sweep_entry) begin
            r_tick    <= '0;
            r_pattern <= '0;
        end else if (mode == MODE_SWEEP) begin
            if (r_tick == TICK_LAST) begin
                r_tick    <= '0;
                r_pattern <= r_pattern + 1'b1;  // 15 wraps to 0
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    // Output register and its one-cycle-delayed copy used for 'changed'.
    // On sweep entry the output shows the freshly restarted pattern (0)
    // immediately rather than whatever the pattern held before.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q <= MODE_SWITCH;
            r_out    <= '0;
            r_out_q  <= '0;
        end else begin
            r_mode_q <= mode;
            r_out_q  <= r_out;
            if (w_sweep_entry) begin
                r_out <= '0;
            end else if (mode == MODE_SWEEP) begin
                r_out <= r_pattern;
            end else begin
                r_out <= w_stable;
            end
        end
    end

    assign a       = r_out[0];
    assign b       = r_out[1];
    assign c       = r_out[2];
    assign d       = r_out[3];
    // Both operands are registers cleared by reset, so this is 0 right after
    // reset and only rises when the output vector actually moves.
    assign changed = (r_out != r_out_q);

endmodule : or_input_conditioner

// File: tb/tb_or_input_conditioner.sv
// ----------------------------------------------------------------------------
// tb_or_input_conditioner
// Scoreboard bench: a reference model computes the expected {d,c,b,a,changed}
// for every clock edge from the input history and queues it; a monitor pops
// and compares one entry per cycle. Directed scenarios are followed by a long
// randomized run.
// ----------------------------------------------------------------------------
module tb_or_input_conditioner;
    import or_lab_pkg::*;

    localparam int DC = 4;   // debounce cycles
    localparam int SP = 10;  // sweep period

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       mode   = 1'b0;
    logic [3:0] sw_raw = 4'h0;
    logic       a, b, c, d, changed;

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b1;

    typedef struct packed {
        logic [3:0] outv;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    or_input_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .SWEEP_PERIOD    (SP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .mode    (mode),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .changed (changed)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Debounce rule: a bit's stable level flips when the
    // level seen after the 2-flop synchronizer (raw sampled two edges ago)
    // has differed from it over the last DC edges. Sweep rule: output after
    // the k-th edge since entering sweep is ((k-1)/SP) mod 16, 0 at entry.
    // ------------------------------------------------------------------
    logic [3:0] m_hist[$];
    logic [3:0] m_stable   = 4'h0;
    logic [3:0] m_out      = 4'h0;
    logic       m_mode_prev = 1'b0;
    int         m_age      = 0;

    initial begin : model
        logic [3:0] new_out;
        logic [3:0] new_stable;
        logic [3:0] tmp;
        bit         all_diff;
        exp_t       e;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_stable    = 4'h0;
                m_out       = 4'h0;
                m_mode_prev = 1'b0;
                m_age       = 0;
                m_hist.delete();
                for (int i = 0; i < DC + 2; i++) m_hist.push_front(4'h0);
                e.outv = 4'h0;
                e.chg  = 1'b0;
            end else begin
                m_hist.push_front(sw_raw);
                void'(m_hist.pop_back());
                if (mode) begin
                    if (!m_mode_prev) begin
                        m_age   = 0;
                        new_out = 4'h0;
                    end else begin
                        new_out = 4'((m_age / SP) % 16);
                        m_age++;
                    end
                end else begin
                    new_out = m_stable;
                end
                new_stable = m_stable;
                for (int bb = 0; bb < 4; bb++) begin
                    all_diff = 1'b1;
                    for (int i = 2; i < DC + 2; i++) begin
                        tmp = m_hist[i];
                        if (tmp[bb] == m_stable[bb]) all_diff = 1'b0;
                    end
                    if (all_diff) new_stable[bb] = ~m_stable[bb];
                end
                e.outv      = new_out;
                e.chg       = (new_out != m_out);
                m_out       = new_out;
                m_mode_prev = mode;
                m_stable    = new_stable;
            end
            if (run) exp_q.push_back(e);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: the DUT presents an output every cycle.
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_out_chg", {3'b000, d, c, b, a, changed}, {3'b000, e.outv, e.chg});
            end else if (run) begin
                chk("sb_queue_empty", 8'h01, 8'h00);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int pulses;
        int rate;

        // Reset with all switches high.
        rst    = 1'b1;
        mode   = 1'b0;
        sw_raw = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) chk("rel_edge6_out", {4'h0, d, c, b, a}, 8'h00);
            if (i == 7) chk("rel_edge7_out_chg", {3'b000, d, c, b, a, changed}, {3'b000, 4'hF, 1'b1});
            if (i == 8) chk("rel_edge8_chg", {7'h0, changed}, 8'h00);
        end

        // Glitch on bit1 shorter than the debounce window.
        @(negedge clk);
        sw_raw = 4'h0;
        repeat (12) @(negedge clk);
        sw_raw = 4'h2;
        repeat (2) @(negedge clk);
        sw_raw = 4'h0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("glitch_b_chg", {6'h0, b, changed}, 8'h00);
        end

        // Sweep for 170 cycles.
        @(negedge clk);
        mode   = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 170; i++) begin
            @(posedge clk);
            #1;
            if (changed) pulses++;
            if (i == 161) chk("sweep_at_15", {4'h0, d, c, b, a}, 8'h0F);
            if (i == 162) chk("sweep_wrap_0", {3'b000, d, c, b, a, changed}, 8'h01);
        end
        chk("sweep_pulse_count", 8'(pulses), 8'd16);

        // Switch mode round trip.
        @(negedge clk);
        mode   = 1'b0;
        sw_raw = 4'h3;
        repeat (10) @(negedge clk);
        mode = 1'b1;
        for (int i = 1; i <= 55; i++) begin
            @(posedge clk);
            #1;
        end
        chk("sweep_at_5", {4'h0, d, c, b, a}, 8'h05);
        @(negedge clk);
        mode = 1'b0;
        @(posedge clk);
        #1;
        chk("to_switch_out", {4'h0, d, c, b, a}, 8'h03);
        repeat (2) @(negedge clk);
        mode = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 1)  chk("to_sweep_out0", {4'h0, d, c, b, a}, 8'h00);
            if (i == 11) chk("to_sweep_hold0", {4'h0, d, c, b, a}, 8'h00);
            if (i == 12) chk("to_sweep_out1", {4'h0, d, c, b, a}, 8'h01);
        end

        // Reset mid-sweep with a debounce in progress.
        for (int i = 13; i <= 89; i++) @(posedge clk);
        @(negedge clk);
        sw_raw = 4'hC;
        repeat (4) @(negedge clk);
        chk("midop_pattern9", {4'h0, d, c, b, a}, 8'h09);
        rst  = 1'b1;
        mode = 1'b0;
        @(negedge clk);
        chk("midop_reset_out", {3'b000, d, c, b, a, changed}, 8'h00);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) chk("midop_edge6", {4'h0, d, c, b, a}, 8'h00);
            if (i == 7) chk("midop_edge7", {3'b000, d, c, b, a, changed}, {3'b000, 4'hC, 1'b1});
        end

        // Randomized run: switch chatter at varying rates, mode flips, resets.
        rate = 6;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ((n % 200) == 0) rate = $urandom_range(1, 12);
            rst = ($urandom_range(0, 499) == 0);
            for (int bb = 0; bb < 4; bb++)
                if ($urandom_range(0, rate) == 0) sw_raw[bb] = ~sw_raw[bb];
            if ($urandom_range(0, 79) == 0) mode = ~mode;
        end

        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_or_input_conditioner
